// File: rtl/joy_serial_emulator.sv
// Emulates the cascaded 74HC165 joystick chain: samples JOY_CLK/JOY_LOAD in clk12 and shifts out 24 bits.
// Define JOY_GLITCH_FILTER_EN to add a third sample flop that rejects 1-cycle input glitches.
module joy_serial_emulator #(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic        clk12,
  input  logic        RESET_L,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic [4:0]  bit_cnt,
  output logic        frame_strobe,
  output logic        link_ok
);
  localparam logic [1:0]  ST_LOADING  = 2'd0;
  localparam logic [1:0]  ST_SHIFTING = 2'd1;
  localparam logic [1:0]  ST_DONE     = 2'd2;
  localparam logic [15:0] WDOG_LIMIT  = 16'(WDOG_CYCLES);

  logic clk_meta_q, clk_sync_q, ld_meta_q, ld_sync_q;
  logic clks, lds, clks_d_q, lds_d_q;

  always_ff @(posedge clk12 or negedge RESET_L) begin
    if (!RESET_L) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      ld_meta_q  <= 1'b1;
      ld_sync_q  <= 1'b1;
      clks_d_q   <= 1'b1;
      lds_d_q    <= 1'b1;
    end else begin
      clk_meta_q <= joy_clk;
      clk_sync_q <= clk_meta_q;
      ld_meta_q  <= joy_load;
      ld_sync_q  <= ld_meta_q;
      clks_d_q   <= clks;
      lds_d_q    <= lds;
    end
  end

`ifdef JOY_GLITCH_FILTER_EN
  logic clk_old_q, ld_old_q;

  always_ff @(posedge clk12 or negedge RESET_L) begin
    if (!RESET_L) begin
      clk_old_q <= 1'b1;
      ld_old_q  <= 1'b1;
    end else begin
      clk_old_q <= clk_sync_q;
      ld_old_q  <= ld_sync_q;
    end
  end

  // Follow the input only when two consecutive synchronised samples agree; otherwise hold.
  assign clks = (clk_sync_q == clk_old_q) ? clk_sync_q : clks_d_q;
  assign lds  = (ld_sync_q == ld_old_q) ? ld_sync_q : lds_d_q;
`else
  assign clks = clk_sync_q;
  assign lds  = ld_sync_q;
`endif

  logic [23:0] sreg_q, sreg_d, par_word;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic        strobe_q, strobe_d;
  logic [15:0] wdog_q, wdog_d;
  logic        link_q, link_d;
  logic        shift, load_fall;

  // Bit 0 is shifted out first.
  assign par_word = {joystick1[7], joystick1[9], joystick1[11], joystick1[10],
                     joystick2[7], joystick2[9], joystick2[11], joystick2[10],
                     joystick2[0], joystick2[1], joystick2[2], joystick2[3],
                     joystick2[4], joystick2[5], joystick2[6], joystick2[8],
                     joystick1[0], joystick1[1], joystick1[2], joystick1[3],
                     joystick1[4], joystick1[5], joystick1[6], joystick1[8]};

  assign shift     = clks & ~clks_d_q & lds & lds_d_q;
  assign load_fall = lds_d_q & ~lds;

  always_comb begin
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    strobe_d = 1'b0;
    if (!lds) begin
      sreg_d  = par_word;
      cnt_d   = 5'd0;
      state_d = ST_LOADING;
    end else begin
      if (shift) sreg_d = {1'b1, sreg_q[23:1]};
      case (state_q)
        ST_LOADING:  state_d = ST_SHIFTING;
        ST_SHIFTING: begin
          if (shift) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              state_d  = ST_DONE;
              strobe_d = 1'b1;
            end
          end
        end
        ST_DONE:     state_d = ST_DONE;
        default:     state_d = ST_LOADING;
      endcase
    end
  end

  always_comb begin
    wdog_d = 16'd0;
    if (!load_fall) wdog_d = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    link_d = link_q;
    if (load_fall) link_d = 1'b1;
    else if (wdog_d >= WDOG_LIMIT) link_d = 1'b0;
  end

  always_ff @(posedge clk12 or negedge RESET_L) begin
    if (!RESET_L) begin
      sreg_q   <= '1;
      cnt_q    <= 5'd0;
      state_q  <= ST_LOADING;
      strobe_q <= 1'b0;
      wdog_q   <= 16'd0;
      link_q   <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      strobe_q <= strobe_d;
      wdog_q   <= wdog_d;
      link_q   <= link_d;
    end
  end

  assign joy_data     = sreg_q[0];
  assign bit_cnt      = cnt_q;
  assign frame_strobe = strobe_q;
  assign link_ok      = link_q;
endmodule

// File: doc/joy_serial_emulator.md
# joy_serial_emulator

Emulates the three-wire joystick shift-register chain (two cascaded 12-bit active-low joystick words) so the 24-bit serial joystick reader can be driven from a local source: another board, a bench model, or a keyboard-to-joystick translator. Samples the asynchronous JOY_CLK/JOY_LOAD lines in the system clock domain and drives JOY_DATA with 74HC165-equivalent semantics. Also reports whether the reader is actively polling.

## Interface
- WDOG_CYCLES, 65535: clk12 cycles without a JOY_LOAD falling edge before link_ok drops.
- clk12  in  1  system clock; must be at least 8× the JOY_CLK frequency.
- RESET_L  in  1  reset, asynchronous, active-low.
- joystick1  in  12  player-1 parallel word, active-low (1 = released).
- joystick2  in  12  player-2 parallel word, active-low.
- joy_clk  in  1  JOY_CLK from the reader, asynchronous.
- joy_load  in  1  JOY_LOAD from the reader, asynchronous, active-low parallel load.
- joy_data  out  1  JOY_DATA to the reader.
- bit_cnt  out  5  number of bits shifted since the last load, saturating at 24.
- frame_strobe  out  1  one-cycle pulse when the 24th shift completes.
- link_ok  out  1  high while the reader issues loads within WDOG_CYCLES.

## Operation
- **Input synchronisers.** joy_clk and joy_load each pass through a 2-flop synchroniser. The synchronised values are clks and lds; their previous-cycle copies are clks_d and lds_d.
- **Serial order.** Shift order, bit 0 first, is fixed:
  - j1[8], j1[6], j1[5], j1[4], j1[3], j1[2], j1[1], j1[0]
  - j2[8], j2[6], j2[5], j2[4], j2[3], j2[2], j2[1], j2[0]
  - j2[10], j2[11], j2[9], j2[7]
  - j1[10], j1[11], j1[9], j1[7]
- **Load.** While lds=0, the 24-bit shift register reloads every cycle from the joystick inputs in the serial order, and bit_cnt=0. The register freezes on the cycle lds becomes 1.
- **Shift.** A shift occurs when clks=1, clks_d=0, lds=1 and lds_d=1 in the same cycle. On a shift:
  - the register moves one position toward bit 0;
  - 1 is filled in at bit 23;
  - bit_cnt increments, saturating at 24.
- **Load dominates.** A clock edge in any cycle where lds or lds_d is 0 is ignored. This handles the reader raising JOY_LOAD immediately after a JOY_CLK rise.
- **Output.** joy_data is always register bit 0, and it is registered.
- **Frame strobe.** frame_strobe pulses on the shift that takes bit_cnt from 23 to 24. Shifts beyond 24 output 1 and produce no further strobe.
- **States.** The control is a three-state machine:
  - LOADING (lds=0): moves to SHIFTING when lds becomes 1.
  - SHIFTING (bit_cnt<24): moves to DONE on the 24th shift; moves to LOADING on lds=0.
  - DONE: moves to LOADING on lds=0.
- **Mid-frame load.** lds=0 in any state aborts the frame. bit_cnt returns to 0 and the register reloads without a strobe.
- **Watchdog.** A 16-bit counter clears on each lds falling edge (lds_d=1, lds=0) and otherwise increments, saturating.
  - link_ok=1 from the cycle after a falling edge.
  - link_ok=0 when the counter reaches WDOG_CYCLES.
- **Reset values.**
  - Shift register: all 1s.
  - joy_data=1, bit_cnt=0, frame_strobe=0, link_ok=0, watchdog counter=0, state=LOADING.
  - Synchroniser flops: 1.

## Timing
- joy_data reflects a shift 3 clk12 cycles after the joy_clk rise: 2 synchroniser cycles plus 1 output-register cycle. With the JOY_GLITCH_FILTER_EN macro defined, the delay is 4 cycles.
- The reader samples on the next JOY_CLK rise, so with JOY_CLK period ≥ 8 clk12 cycles every bit is stable ≥ 4 cycles before sampling.
- Parallel inputs are captured 2–3 cycles after joy_load falls and are tracked until load is released.
- Reset assertion takes effect immediately, regardless of clock. Deassertion is not synchronised internally; the upstream reset source is responsible.

## Configuration
- **JOY_GLITCH_FILTER_EN defined:** a third flop is added on each input. clks and lds change only when the last two synchronised samples agree, so 1-cycle glitches are rejected. Latency increases by 1 cycle.
- **Undefined:** the plain 2-flop synchronisers are used with no filtering.

## Test plan
- **Reset:** RESET_L=0 for 5 cycles with inputs toggling -> joy_data=1, bit_cnt=0, link_ok=0, frame_strobe=0.
- **Full frame:**
  - Stimulus: joystick1=12'hFFE, joystick2=12'hFFF; run the reader sequence (load low 1 period, then 25 clocks, period 32 cycles).
  - Response: sampled bits 2..25 are all 1 except the bit at index 7 (j1[0]) = 0; frame_strobe pulses once; bit_cnt=24.
- **Over-clocking:** 30 clocks after load -> bits 24..29 read 1; bit_cnt stays 24; exactly one strobe.
- **Mid-frame reload:**
  - Stimulus: joy_load low after 10 shifts with joystick2 changed to 12'h0FF.
  - Response: bit_cnt=0, no strobe; the next frame reads the new value.
- **Load/clock coincidence:** joy_clk rises in the same cycle joy_load rises -> no shift; first sampled bit is j1[8].
- **Watchdog:** with WDOG_CYCLES=100, stop loads -> link_ok falls exactly 100 cycles after the last falling edge; a new load brings link_ok back to 1.
- **Glitch rejection:** with JOY_GLITCH_FILTER_EN, a 1-cycle joy_clk pulse -> no shift. Without the macro, the same pulse shifts once.
